// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Issue/result bundle between the MIPS control path and muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, Funct, A, B, flush, input busy, done, HI, LO);
  modport slave  (input start, Funct, A, B, flush, output busy, done, HI, LO);
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative shift-add multiply / restoring divide with HI/LO registers.
//            Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they act unsigned.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave mdu
);
  localparam logic [5:0] c_FN_MULT  = 6'h18;
  localparam logic [5:0] c_FN_MULTU = 6'h19;
  localparam logic [5:0] c_FN_DIV   = 6'h1A;
  localparam logic [5:0] c_FN_DIVU  = 6'h1B;
  localparam logic [5:0] c_FN_MTHI  = 6'h11;
  localparam logic [5:0] c_FN_MTLO  = 6'h13;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_FIX  = 2'd2;

  localparam int              c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [c_CNT_W-1:0] cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               op_div_q, neg_res_q, neg_rem_q;

  logic w_is_mul, w_is_div, w_signed_op, w_idle_req, w_accept;

  assign w_is_mul   = (mdu.Funct == c_FN_MULT) || (mdu.Funct == c_FN_MULTU);
  assign w_is_div   = (mdu.Funct == c_FN_DIV)  || (mdu.Funct == c_FN_DIVU);
`ifdef MULDIV_SIGNED_EN
  assign w_signed_op = (mdu.Funct == c_FN_MULT) || (mdu.Funct == c_FN_DIV);
`else
  assign w_signed_op = 1'b0;
`endif
  // flush in IDLE drops any coincident start, MTHI/MTLO included
  assign w_idle_req = (state_q == c_S_IDLE) && mdu.start && !mdu.flush;
  assign w_accept   = w_idle_req && (w_is_mul || w_is_div);

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_a_neg = w_signed_op & mdu.A[WIDTH-1];
  assign w_b_neg = w_signed_op & mdu.B[WIDTH-1];
  assign w_a_mag = w_a_neg ? -mdu.A : mdu.A;
  assign w_b_mag = w_b_neg ? -mdu.B : mdu.B;

  // Multiply: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_unused;

  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, opnd_q};
  assign w_div_ge    = ~w_div_diff[WIDTH+1];
  assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], w_div_ge};
  assign w_unused    = w_div_diff[WIDTH];

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_hi_fix, w_lo_fix;

  assign w_prod_fix = neg_res_q ? -acc_q : acc_q;
  assign w_quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign w_hi_fix   = op_div_q ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_fix   = op_div_q ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= c_S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE: if (w_accept) state_d = c_S_RUN;
      c_S_RUN: begin
        if (mdu.flush)                state_d = c_S_IDLE;
        else if (cnt_q == c_CNT_LAST) state_d = c_S_FIX;
      end
      c_S_FIX:  state_d = c_S_IDLE;
      default:  state_d = c_S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != c_S_IDLE);
    done_d = (state_q == c_S_FIX) && !mdu.flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (w_accept) begin
      cnt_q     <= '0;
      op_div_q  <= w_is_div;
      // A zero divisor returns all-ones quotient unsigned; remainder negation restores A
      neg_res_q <= (w_a_neg ^ w_b_neg) & (|mdu.B);
      neg_rem_q <= w_a_neg & w_is_div;
      if (w_is_div) begin
        acc_q  <= {{WIDTH{1'b0}}, w_a_mag};
        opnd_q <= w_b_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, w_b_mag};
        opnd_q <= w_a_mag;
      end
    end else if (state_q == c_S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= op_div_q ? w_div_next : w_mul_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state_q == c_S_FIX) && !mdu.flush) begin
      hi_q <= w_hi_fix;
      lo_q <= w_lo_fix;
    end else if (w_idle_req && (mdu.Funct == c_FN_MTHI)) begin
      hi_q <= mdu.A;
    end else if (w_idle_req && (mdu.Funct == c_FN_MTLO)) begin
      lo_q <= mdu.A;
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit; honours MULDIV_SIGNED_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B, FN_MTHI = 6'h11, FN_MTLO = 6'h13;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  res_t sb_q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_unit_if #(.WIDTH(W)) mdu ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .mdu(mdu));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic res_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [2*W-1:0] p;
    logic signed [W-1:0] sa, sb;
    bit sgn;
    sgn = SIGNED_EN && (f == FN_MULT || f == FN_DIV);
    sa = a;
    sb = b;
    if (f == FN_MULT || f == FN_MULTU) begin
      if (sgn) p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      else     p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      r.hi = p[2*W-1:W];
      r.lo = p[W-1:0];
    end else if (b == '0) begin
      r.lo = '1;
      r.hi = a;
    end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      r.lo = a;
      r.hi = '0;
    end else if (sgn) begin
      r.lo = sa / sb;
      r.hi = sa % sb;
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of cycle k+1.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    sb_q.push_back(model(f, a, b));
    mdu.start = 1'b1;
    mdu.Funct = f;
    mdu.A = a;
    mdu.B = b;
    @(negedge clk);
    mdu.start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output bit seen, output int lat, output bit busy_ok,
                           output logic [W-1:0] hi, output logic [W-1:0] lo);
    seen = 1'b0;
    busy_ok = 1'b1;
    lat = lat0;
    hi = '0;
    lo = '0;
    while (!seen && lat < W + 12) begin
      if (mdu.done === 1'b1) begin
        seen = 1'b1;
        if (mdu.busy !== 1'b0) busy_ok = 1'b0;
        hi = mdu.HI;
        lo = mdu.LO;
      end else begin
        if (mdu.busy !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  function automatic res_t pop_exp();
    res_t e;
    e.hi = 'x;
    e.lo = 'x;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mdu.busy !== 1'b0 || mdu.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0", mdu.busy, mdu.done);
    end
    checks++;
    if (mdu.HI !== '0 || mdu.LO !== '0) begin
      errors++;
      $display("FAIL reset_hilo: HI=%h LO=%h want 0 0", mdu.HI, mdu.LO);
    end
  endtask

  task automatic test_multu_max();
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo;
    res_t e;
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || lat != W + 2) begin
      errors++;
      $display("FAIL multu_latency: got %0d seen=%0b want %0d", lat, seen, W + 2);
    end
    checks++;
    if (!bok) begin errors++; $display("FAIL multu_busy: busy window wrong, want 1 for cycles 1..%0d", W + 1); end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL multu_max_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
    end
    last_hi = e.hi;
    last_lo = e.lo;
    @(negedge clk);
    checks++;
    if (mdu.done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b want 0 after pulse", mdu.done); end
  endtask

  task automatic test_mult_signed();
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo;
    res_t e;
    issue(FN_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || !bok || lat != W + 2 || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL mult_signed: got %h_%h lat=%0d busy_ok=%0b want %h_%h lat=%0d",
               hi, lo, lat, bok, e.hi, e.lo, W + 2);
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_back_to_back();
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo;
    res_t e;
    issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || !bok || lat != W + 2 || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("FAIL div_signed: got %h_%h lat=%0d want %h_%h", hi, lo, lat, e.hi, e.lo);
    end
    issue(FN_DIVU, 32'd7, 32'd0);
    checks++;
    if (mdu.done !== 1'b0 || mdu.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b want 0 1", mdu.done, mdu.busy);
    end
    wait_done(1, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || !bok || lat != W + 2 || hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL divu_by_zero: got %h_%h lat=%0d want 00000007_ffffffff lat=%0d", hi, lo, lat, W + 2);
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_mthi_mtlo();
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo;
    res_t e;
    mdu.start = 1'b1; mdu.Funct = FN_MTHI; mdu.A = 32'h1234_5678;
    @(negedge clk);
    mdu.start = 1'b0;
    checks++;
    if (mdu.HI !== 32'h1234_5678 || mdu.LO !== last_lo || mdu.busy !== 1'b0 || mdu.done !== 1'b0) begin
      errors++;
      $display("FAIL mthi: HI=%h LO=%h busy=%b done=%b want 12345678 %h 0 0", mdu.HI, mdu.LO, mdu.busy, mdu.done, last_lo);
    end
    mdu.start = 1'b1; mdu.Funct = FN_MTLO; mdu.A = 32'hCAFE_F00D;
    @(negedge clk);
    mdu.start = 1'b0;
    checks++;
    if (mdu.LO !== 32'hCAFE_F00D || mdu.HI !== 32'h1234_5678 || mdu.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: HI=%h LO=%h busy=%b want 12345678 cafef00d 0", mdu.HI, mdu.LO, mdu.busy);
    end
    mdu.Funct = 6'h20;  // unrelated funct must be ignored
    mdu.start = 1'b1;
    @(negedge clk);
    mdu.start = 1'b0;
    checks++;
    if (mdu.busy !== 1'b0 || mdu.HI !== 32'h1234_5678 || mdu.LO !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL other_funct: busy=%b HI=%h LO=%h want 0 12345678 cafef00d", mdu.busy, mdu.HI, mdu.LO);
    end
    issue(FN_MULTU, 32'd3, 32'd4);
    wait_done(1, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || !bok || hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL multu_small: got %h_%h want 00000000_0000000c", hi, lo);
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_busy_start();
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo;
    res_t e;
    issue(FN_MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    mdu.start = 1'b1; mdu.Funct = FN_DIVU; mdu.A = 32'd100; mdu.B = 32'd3;
    @(negedge clk);
    mdu.start = 1'b0;
    wait_done(5, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || !bok || lat != W + 2 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL start_while_busy: got %h_%h lat=%0d want 00000000_0000002a lat=%0d", hi, lo, lat, W + 2);
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_flush();
    bit done_seen;
    bit busy_seen;
    issue(FN_MULTU, 32'h0000_DEAD, 32'h0000_BEEF);
    void'(sb_q.pop_back());
    repeat (9) @(negedge clk);
    mdu.flush = 1'b1;
    @(negedge clk);
    mdu.flush = 1'b0;
    checks++;
    if (mdu.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: busy=%b want 0", mdu.busy); end
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (mdu.done !== 1'b0) done_seen = 1'b1;
      if (mdu.busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_seen || busy_seen) begin
      errors++;
      $display("FAIL flush_quiet: done_seen=%0b busy_seen=%0b want 0 0", done_seen, busy_seen);
    end
    checks++;
    if (mdu.HI !== last_hi || mdu.LO !== last_lo) begin
      errors++;
      $display("FAIL flush_hilo: got %h_%h want %h_%h", mdu.HI, mdu.LO, last_hi, last_lo);
    end
    mdu.flush = 1'b1; mdu.start = 1'b1; mdu.Funct = FN_MTHI; mdu.A = 32'h5555_AAAA;
    @(negedge clk);
    mdu.flush = 1'b0; mdu.start = 1'b0;
    checks++;
    if (mdu.HI !== last_hi || mdu.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_prio: HI=%h busy=%b want %h 0", mdu.HI, mdu.busy, last_hi);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo;
    res_t e;
    issue(FN_DIV, 32'd1000, 32'd7);
    void'(sb_q.pop_back());
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (mdu.busy !== 1'b0 || mdu.done !== 1'b0 || mdu.HI !== '0 || mdu.LO !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b HI=%h LO=%h want 0 0 0 0", mdu.busy, mdu.done, mdu.HI, mdu.LO);
    end
    last_hi = '0;
    last_lo = '0;
    issue(FN_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(1, seen, lat, bok, hi, lo);
    e = pop_exp();
    checks++;
    if (!seen || !bok || lat != W + 2 || hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL after_reset: got %h_%h lat=%0d want 00000001_00000000 lat=%0d", hi, lo, lat, W + 2);
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_corners_random();
    logic [5:0]   cf [6] = '{FN_DIV, FN_DIV, FN_DIVU, FN_MULT, FN_MULT, FN_DIV};
    logic [W-1:0] ca [6] = '{32'h8000_0000, 32'hFFFF_FF00, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] cb [6] = '{32'hFFFF_FFFF, 32'd0, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [5:0]   fr [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    bit seen, bok;
    int lat;
    logic [W-1:0] hi, lo, a, b;
    logic [5:0] f;
    res_t e;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        f = cf[i]; a = ca[i]; b = cb[i];
      end else begin
        f = fr[$urandom_range(0, 3)];
        a = $urandom;
        b = (i % 3 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
        if (i % 4 == 0) b = -b;
      end
      issue(f, a, b);
      wait_done(1, seen, lat, bok, hi, lo);
      e = pop_exp();
      checks++;
      if (!seen || !bok || lat != W + 2 || hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("FAIL op%0d f=%h a=%h b=%h: got %h_%h lat=%0d busy_ok=%0b want %h_%h lat=%0d",
                 i, f, a, b, hi, lo, lat, bok, e.hi, e.lo, W + 2);
      end
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  initial begin
    mdu.start = 1'b0;
    mdu.flush = 1'b0;
    mdu.Funct = '0;
    mdu.A = '0;
    mdu.B = '0;
    @(negedge clk);
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_back_to_back();
    test_mthi_mtlo();
    test_busy_start();
    test_flush();
    test_reset_mid();
    test_corners_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that adds the MULT/MULTU/DIV/DIVU/MTHI/MTLO path beside the combinational ALU in the MIPS datapath. It decodes the R-type Funct field itself, runs a one-bit-per-cycle shift-add multiply or restoring divide over WIDTH cycles, and holds the HI/LO result registers. It exposes busy/done so the control unit can stall MFHI/MFLO and further mult/div issue until the result is ready.

## Interface
- WIDTH, 32: operand and HI/LO width; even, ≥4.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  issue request; sampled only when busy=0.
- Funct  in  6  R-type funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
- A  in  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO source).
- B  in  WIDTH  rt operand (divisor, multiplier).
- flush  in  1  cancel in-flight operation (exception/branch squash).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- HI  out  WIDTH  high product / remainder.
- LO  out  WIDTH  low product / quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, Funct ∈ {MULT, MULTU, DIV, DIVU}: latch |A|, |B| (signed ops) or A, B raw; latch result signs; cnt←0; go to RUN.
- IDLE, start=1, Funct=MTHI/MTLO: HI←A or LO←A at the edge; stay IDLE; no busy, no done.
- IDLE, start=1, any other Funct: ignored.
- RUN: one iteration per cycle, cnt increments; after WIDTH iterations (cnt=WIDTH-1 at edge) go to FIX.
  - Multiply: 2·WIDTH-bit accumulator, shift-add on LSB of multiplier.
  - Divide: restoring, remainder WIDTH+1 bits, one quotient bit per cycle.
- FIX: apply sign correction. Product negated if sign(A)^sign(B). Quotient negated if sign(A)^sign(B); remainder takes sign of A. Write HI/LO, pulse done, go to IDLE.
- Divide by zero: no trap. Result is LO=all ones, HI=A. The signed variant returns the same value, with no sign fix. Latency is unchanged.
- Signed overflow, MIN/−1: LO=MIN, HI=0, which falls out of magnitude arithmetic.
- HI/LO change only at the FIX→IDLE edge, on MTHI/MTLO, or on reset. Intermediate values are never visible.
- start while busy=1: ignored. Issuer must stall on busy.
- flush: RUN/FIX→IDLE at next edge. No done; HI/LO keep their prior values. In IDLE, flush has priority over start, and a coincident start is dropped.
- reset: state IDLE; busy=0, done=0, HI=0, LO=0, cnt=0. Takes priority over flush and start, including mid-operation.

## Timing
- Start accepted at edge k (IDLE, start=1).
- busy=1 in cycles k+1 … k+WIDTH+1: WIDTH RUN cycles plus 1 FIX cycle.
- done=1 and new HI/LO visible in cycle k+WIDTH+2. busy=0 in that cycle, so a new start there is accepted (back-to-back issue).
- Total latency is WIDTH+2 cycles and is fixed for all operands, including zero divisor.
- MTHI/MTLO: value visible in cycle k+1.
- done is never asserted for two consecutive cycles.
- busy and done are registered outputs, with no combinational path from inputs.

## Configuration
- MULDIV_SIGNED_EN defined:
  - MULT/DIV use signed semantics: magnitude capture plus FIX-state sign correction.
- MULDIV_SIGNED_EN undefined:
  - MULT behaves as MULTU and DIV as DIVU.
  - FIX state is still traversed, so latency is identical; sign logic is removed.

## Test plan
- WIDTH=32, MULTU A=0xFFFFFFFF B=0xFFFFFFFF at edge k -> busy cycles k+1..k+33; done at k+34 with HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=−3 (0xFFFFFFFD) B=5, MULDIV_SIGNED_EN -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Without the macro -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV A=−7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7 B=0 issued in the done cycle -> accepted; result LO=0xFFFFFFFF, HI=0x00000007.
- MTHI A=0x12345678 -> HI=0x12345678 next cycle, busy stays 0. Then MULTU 3×4 -> HI=0, LO=12.
- MULTU in flight, flush at k+10 -> busy=0 from k+11, no done, HI/LO keep prior values. A start with busy=1 at k+5 -> no effect.
- reset asserted at k+20 mid-DIV -> cycle k+21 shows busy=0, done=0, HI=0, LO=0. A start at k+21 completes normally.
